// File: rtl/cpu_bus_mem_if.sv
// CPU bus bundle for cpu_bus_mem: address/rw/data, read/fault strobes and the ROM load port.
// Latency: none, wires only.
// Backpressure: none; the CPU drives the bus every cycle and results are never stalled.
// Ports: addr, rw (1 = read), data_in, data_out, rd_valid, wr_fault, load_en, load_addr, load_data.
// master = CPU / bench side, slave = memory side.
interface cpu_bus_mem_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int ROM_AW = 15
);
   logic [ADDR_W-1:0] addr;
   logic              rw;
   logic [DATA_W-1:0] data_in;
   logic [DATA_W-1:0] data_out;
   logic              rd_valid;
   logic              wr_fault;
   logic              load_en;
   logic [ROM_AW-1:0] load_addr;
   logic [DATA_W-1:0] load_data;

   modport master (
      output addr, rw, data_in, load_en, load_addr, load_data,
      input  data_out, rd_valid, wr_fault
   );

   modport slave (
      input  addr, rw, data_in, load_en, load_addr, load_data,
      output data_out, rd_valid, wr_fault
   );
endinterface

// File: rtl/cpu_bus_mem.sv
// 2A03 CPU bus memory model: mirrored RAM, write-protected ROM, unmapped space with open bus.
// Latency: read issued at edge N updates data_out/rd_valid at edge N+READ_LAT-1.
// Backpressure: none; one read or write accepted every cycle, results never stall.
// Ports: clock, reset (sync, active-high), bus (cpu_bus_mem_if.slave: addr, rw, data_in,
//        data_out, rd_valid, wr_fault, load_en, load_addr, load_data).
// Option: define CPU_BUS_MEM_OPEN_BUS_EN to return the last bus value on unmapped reads
//         (otherwise unmapped reads return 0 and no latch is built).
module cpu_bus_mem #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 8,
   parameter int                RAM_AW   = 11,
   parameter logic [ADDR_W-1:0] RAM_END  = 16'h1FFF,
   parameter logic [ADDR_W-1:0] ROM_BASE = 16'h8000,
   parameter int                ROM_AW   = 15,
   parameter int                READ_LAT = 1
) (
   input  logic           clock,
   input  logic           reset,
   cpu_bus_mem_if.slave   bus
);

   typedef struct packed {
      logic              vld;
      logic              unm;   // entry came from unmapped space
      logic [DATA_W-1:0] dat;
   } rd_ent_t;

   // Contents are deliberately not reset.
   logic [DATA_W-1:0] ram_mem [2**RAM_AW];
   logic [DATA_W-1:0] rom_mem [2**ROM_AW];

   logic              is_ram;
   logic              is_rom;
   logic [RAM_AW-1:0] ram_idx;
   logic [ROM_AW-1:0] rom_idx;
   logic [DATA_W-1:0] arr_dat;
   logic [DATA_W-1:0] ob_val;
   rd_ent_t           issue_e;
   rd_ent_t           exit_e;

   logic [DATA_W-1:0] data_out_q, data_out_d;
   logic              rd_valid_q, rd_valid_d;
   logic              wr_fault_q, wr_fault_d;

   // RAM has priority over ROM if the windows are ever configured to overlap.
   assign is_ram  = (bus.addr <= RAM_END);
   assign is_rom  = !is_ram && (bus.addr >= ROM_BASE);
   assign ram_idx = bus.addr[RAM_AW-1:0];
   assign rom_idx = ROM_AW'(bus.addr - ROM_BASE);

   // Array read happens at issue; a same-edge load sees the old word (read-before-write).
   always_comb begin
      arr_dat = '0;
      if (is_ram)
         arr_dat = ram_mem[ram_idx];
      else if (is_rom)
         arr_dat = rom_mem[rom_idx];
   end

   always_comb begin
      issue_e     = '0;
      issue_e.vld = bus.rw;
      issue_e.unm = !(is_ram || is_rom);
      issue_e.dat = arr_dat;
   end

   always_ff @(posedge clock) begin
      if (!reset && !bus.rw && is_ram)
         ram_mem[ram_idx] <= bus.data_in;
   end

   // Load port ignores write protection.
   always_ff @(posedge clock) begin
      if (bus.load_en)
         rom_mem[bus.load_addr] <= bus.load_data;
   end

   // READ_LAT-1 staging flops; the output register is the final stage.
   generate
      if (READ_LAT == 1) begin : g_lat1
         assign exit_e = issue_e;
      end else begin : g_pipe
         rd_ent_t pipe_q [READ_LAT-1];
         rd_ent_t pipe_d [READ_LAT-1];

         always_comb begin
            pipe_d[0] = issue_e;
            for (int k = 1; k < READ_LAT-1; k++)
               pipe_d[k] = pipe_q[k-1];
         end

         always_ff @(posedge clock) begin
            if (reset) begin
               for (int k = 0; k < READ_LAT-1; k++)
                  pipe_q[k] <= '0;
            end else begin
               for (int k = 0; k < READ_LAT-1; k++)
                  pipe_q[k] <= pipe_d[k];
            end
         end

         assign exit_e = pipe_q[READ_LAT-2];
      end
   endgenerate

`ifdef CPU_BUS_MEM_OPEN_BUS_EN
   logic [DATA_W-1:0] ob_q, ob_d;

   // Tracks whatever was last on the data bus; unmapped reads drive nothing, so they keep it.
   always_comb begin
      ob_d = ob_q;
      if (!bus.rw)
         ob_d = bus.data_in;
      else if (!issue_e.unm)
         ob_d = arr_dat;
   end

   always_ff @(posedge clock) begin
      if (reset)
         ob_q <= '0;
      else
         ob_q <= ob_d;
   end

   assign ob_val = ob_q;
`else
   assign ob_val = '0;
`endif

   always_comb begin
      data_out_d = data_out_q;
      rd_valid_d = exit_e.vld;
      wr_fault_d = !bus.rw && is_rom;
      if (exit_e.vld)
         data_out_d = exit_e.unm ? ob_val : exit_e.dat;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         data_out_q <= '0;
         rd_valid_q <= 1'b0;
         wr_fault_q <= 1'b0;
      end else begin
         data_out_q <= data_out_d;
         rd_valid_q <= rd_valid_d;
         wr_fault_q <= wr_fault_d;
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.wr_fault = wr_fault_q;

endmodule

// File: tb/tb_cpu_bus_mem.sv
// Directed bench for cpu_bus_mem: default instance (READ_LAT=1) and a READ_LAT=3 instance.
// Latency: checks sample 1 time unit after each posedge.
// Backpressure: none.
module tb_cpu_bus_mem;

`ifdef CPU_BUS_MEM_OPEN_BUS_EN
   localparam bit OB_EN = 1'b1;
`else
   localparam bit OB_EN = 1'b0;
`endif

   logic clk;
   logic rst1;
   logic rst3;
   int   checks;
   int   errors;

   cpu_bus_mem_if #(.ADDR_W(16), .DATA_W(8), .ROM_AW(15)) bus1 ();
   cpu_bus_mem_if #(.ADDR_W(16), .DATA_W(8), .ROM_AW(15)) bus3 ();

   cpu_bus_mem #(.READ_LAT(1)) u_dut1 (.clock(clk), .reset(rst1), .bus(bus1));
   cpu_bus_mem #(.READ_LAT(3)) u_dut3 (.clock(clk), .reset(rst3), .bus(bus3));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Idle = write to unmapped space: no read issued, no fault.
   task automatic cpu1(input logic rw, input logic [15:0] a, input logic [7:0] d);
      bus1.rw = rw; bus1.addr = a; bus1.data_in = d;
   endtask

   task automatic cpu3(input logic rw, input logic [15:0] a, input logic [7:0] d);
      bus3.rw = rw; bus3.addr = a; bus3.data_in = d;
   endtask

   task automatic test_reset();
      rst1 = 1'b1; rst3 = 1'b1;
      cpu1(1'b0, 16'h4000, 8'h00);
      cpu3(1'b0, 16'h4000, 8'h00);
      bus1.load_en = 1'b0; bus1.load_addr = '0; bus1.load_data = '0;
      bus3.load_en = 1'b0; bus3.load_addr = '0; bus3.load_data = '0;
      step(); step();
      checks++; if (bus1.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout1 got %h exp 00", bus1.data_out); end
      checks++; if (bus1.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rdv1 got %b exp 0", bus1.rd_valid); end
      checks++; if (bus1.wr_fault !== 1'b0) begin errors++; $display("FAIL reset_wf1 got %b exp 0", bus1.wr_fault); end
      checks++; if (bus3.data_out !== 8'h00) begin errors++; $display("FAIL reset_dout3 got %h exp 00", bus3.data_out); end
      checks++; if (bus3.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rdv3 got %b exp 0", bus3.rd_valid); end
      rst1 = 1'b0; rst3 = 1'b0;
   endtask

   task automatic test_ram_mirror();
      cpu1(1'b0, 16'h0012, 8'h55); step();
      checks++; if (bus1.rd_valid !== 1'b0) begin errors++; $display("FAIL ram_wr_rdv got %b exp 0", bus1.rd_valid); end
      checks++; if (bus1.wr_fault !== 1'b0) begin errors++; $display("FAIL ram_wr_wf got %b exp 0", bus1.wr_fault); end
      cpu1(1'b1, 16'h0812, 8'h00); step();
      checks++; if (bus1.rd_valid !== 1'b1) begin errors++; $display("FAIL mirror_0812_rdv got %b exp 1", bus1.rd_valid); end
      checks++; if (bus1.data_out !== 8'h55) begin errors++; $display("FAIL mirror_0812 got %h exp 55", bus1.data_out); end
      cpu1(1'b1, 16'h1812, 8'h00); step();
      checks++; if (bus1.data_out !== 8'h55) begin errors++; $display("FAIL mirror_1812 got %h exp 55", bus1.data_out); end
      // Unmapped write: discarded, no fault.
      cpu1(1'b0, 16'h2000, 8'h11); step();
      checks++; if (bus1.wr_fault !== 1'b0) begin errors++; $display("FAIL unmapped_wr_wf got %b exp 0", bus1.wr_fault); end
      checks++; if (bus1.data_out !== 8'h55) begin errors++; $display("FAIL dout_hold got %h exp 55", bus1.data_out); end
   endtask

   task automatic test_rom_protect();
      cpu1(1'b0, 16'h4000, 8'h00);
      bus1.load_en = 1'b1; bus1.load_addr = 15'd0; bus1.load_data = 8'hA9; step();
      bus1.load_en = 1'b0;
      cpu1(1'b0, 16'h8000, 8'h00); step();
      checks++; if (bus1.wr_fault !== 1'b1) begin errors++; $display("FAIL rom_wf_pulse got %b exp 1", bus1.wr_fault); end
      checks++; if (bus1.rd_valid !== 1'b0) begin errors++; $display("FAIL rom_wr_rdv got %b exp 0", bus1.rd_valid); end
      cpu1(1'b0, 16'h4000, 8'h00); step();
      checks++; if (bus1.wr_fault !== 1'b0) begin errors++; $display("FAIL rom_wf_end got %b exp 0", bus1.wr_fault); end
      cpu1(1'b1, 16'h8000, 8'h00); step();
      checks++; if (bus1.data_out !== 8'hA9) begin errors++; $display("FAIL rom_protected got %h exp a9", bus1.data_out); end
      checks++; if (bus1.wr_fault !== 1'b0) begin errors++; $display("FAIL rom_rd_wf got %b exp 0", bus1.wr_fault); end
   endtask

   task automatic test_open_bus();
      cpu1(1'b1, 16'h0012, 8'h00); step();
      checks++; if (bus1.data_out !== 8'h55) begin errors++; $display("FAIL ob_ram_rd got %h exp 55", bus1.data_out); end
      cpu1(1'b1, 16'h4020, 8'h00); step();
      checks++; if (bus1.rd_valid !== 1'b1) begin errors++; $display("FAIL ob_rdv got %b exp 1", bus1.rd_valid); end
      checks++; if (bus1.data_out !== (OB_EN ? 8'h55 : 8'h00)) begin errors++; $display("FAIL ob_4020 got %h exp %h", bus1.data_out, OB_EN ? 8'h55 : 8'h00); end
      // Unmapped write still drives the bus value.
      cpu1(1'b0, 16'h5000, 8'h3C); step();
      cpu1(1'b1, 16'h5000, 8'h00); step();
      checks++; if (bus1.data_out !== (OB_EN ? 8'h3C : 8'h00)) begin errors++; $display("FAIL ob_after_wr got %h exp %h", bus1.data_out, OB_EN ? 8'h3C : 8'h00); end
   endtask

   task automatic test_same_edge();
      cpu1(1'b0, 16'h4000, 8'h00);
      bus1.load_en = 1'b1; bus1.load_addr = 15'd5; bus1.load_data = 8'hEE; step();
      bus1.load_data = 8'h77;
      cpu1(1'b1, 16'h8005, 8'h00); step();
      bus1.load_en = 1'b0;
      checks++; if (bus1.data_out !== 8'hEE) begin errors++; $display("FAIL same_edge_old got %h exp ee", bus1.data_out); end
      step();
      checks++; if (bus1.data_out !== 8'h77) begin errors++; $display("FAIL same_edge_new got %h exp 77", bus1.data_out); end
   endtask

   task automatic test_reset_write();
      rst1 = 1'b1;
      cpu1(1'b0, 16'h0012, 8'h99); step();
      rst1 = 1'b0;
      checks++; if (bus1.data_out !== 8'h00) begin errors++; $display("FAIL rst_dout got %h exp 00", bus1.data_out); end
      cpu1(1'b0, 16'h8001, 8'h00); rst1 = 1'b1; step();
      rst1 = 1'b0;
      checks++; if (bus1.wr_fault !== 1'b0) begin errors++; $display("FAIL rst_rom_wf got %b exp 0", bus1.wr_fault); end
      cpu1(1'b1, 16'h0012, 8'h00); step();
      checks++; if (bus1.data_out !== 8'h55) begin errors++; $display("FAIL rst_wr_ignored got %h exp 55", bus1.data_out); end
      cpu1(1'b0, 16'h4000, 8'h00);
   endtask

   task automatic test_lat3_pipeline();
      logic       exp_v;
      logic [7:0] exp_d;
      cpu3(1'b0, 16'h4000, 8'h00);
      for (int i = 0; i < 3; i++) begin
         bus3.load_en = 1'b1; bus3.load_addr = 15'(i); bus3.load_data = 8'(i + 1); step();
      end
      bus3.load_en = 1'b0;
      exp_d = 8'h00;
      for (int i = 0; i < 6; i++) begin
         if (i < 3) cpu3(1'b1, 16'h8000 + 16'(i), 8'h00);
         else       cpu3(1'b0, 16'h4000, 8'h00);
         step();
         exp_v = (i >= 2) && (i <= 4);
         if (exp_v) exp_d = 8'(i - 1);
         checks++; if (bus3.rd_valid !== exp_v) begin errors++; $display("FAIL lat3_rdv[%0d] got %b exp %b", i, bus3.rd_valid, exp_v); end
         checks++; if (bus3.data_out !== exp_d) begin errors++; $display("FAIL lat3_dout[%0d] got %h exp %h", i, bus3.data_out, exp_d); end
      end
   endtask

   task automatic test_lat3_reset();
      cpu3(1'b0, 16'h0012, 8'h55); step();
      cpu3(1'b1, 16'h8000, 8'h00); step();
      cpu3(1'b1, 16'h8001, 8'h00); step();
      cpu3(1'b0, 16'h4000, 8'h00); rst3 = 1'b1; step();
      rst3 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (bus3.rd_valid !== 1'b0) begin errors++; $display("FAIL lat3_flush_rdv[%0d] got %b exp 0", i, bus3.rd_valid); end
         checks++; if (bus3.data_out !== 8'h00) begin errors++; $display("FAIL lat3_flush_dout[%0d] got %h exp 00", i, bus3.data_out); end
         step();
      end
      cpu3(1'b1, 16'h0012, 8'h00); step();
      cpu3(1'b0, 16'h4000, 8'h00); step();
      checks++; if (bus3.rd_valid !== 1'b0) begin errors++; $display("FAIL lat3_post_early got %b exp 0", bus3.rd_valid); end
      step();
      checks++; if (bus3.rd_valid !== 1'b1) begin errors++; $display("FAIL lat3_post_rdv got %b exp 1", bus3.rd_valid); end
      checks++; if (bus3.data_out !== 8'h55) begin errors++; $display("FAIL lat3_post_dout got %h exp 55", bus3.data_out); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_ram_mirror();
      test_rom_protect();
      test_open_bus();
      test_same_edge();
      test_reset_write();
      test_lat3_pipeline();
      test_lat3_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
